cla_share_arb: RTL and testbench

- Round-robin arbiter that time-shares one registered 32-bit carry-lookahead adder (cla_clk) between NREQ independent requesters.
- Each requester offers operands with a valid/ready handshake. At most one request is granted per cycle and steered into the adder.
- A tag pipeline tracks which requester owns each in-flight add and returns the sum to that requester with a one-hot response strobe.
- Sits between the requesting datapath blocks and the single shared cla_clk instance.

---
 rtl/cla_share_arb_pkg.sv | 33 +++
 rtl/cla_clk.sv | 88 ++++++++
 rtl/cla_share_arb_rr_pick.sv | 52 +++++
 rtl/cla_share_arb.sv | 138 +++++++++++++
 tb/tb_cla_share_arb.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/cla_share_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cla_share_arb_pkg
//  Purpose  : Shared types and helpers for the cla_share_arb arbiter slice:
//             tag record carried alongside each in-flight add, index-width
//             and modulo-wrap helpers used by the picker and the top.
//  Revision : 1.0 - initial release
// ============================================================================
package cla_share_arb_pkg;

    // Largest requester count the arbiter supports. Tags are sized for it so
    // the record layout does not change with NREQ.
    localparam int MAX_NREQ  = 8;
    localparam int TAG_IDX_W = $clog2(MAX_NREQ);

    // One tag pipeline stage: does this slot hold a live add, and whose is it.
    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    // Width of a requester index; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (a + b) mod n for a, b already in [0, n). Avoids a general divider.
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b >= n) ? (a + b - n) : (a + b);
    endfunction

endpackage : cla_share_arb_pkg
`default_nettype wire

// File: rtl/cla_clk.sv
`default_nettype none
// ============================================================================
//  Module   : cla_clk
//  Purpose  : Registered carry-lookahead adder. Operands are captured on one
//             edge, the sum is registered on the next (two-stage latency).
//             Built from 4-bit lookahead groups; WIDTH must be a multiple of 4.
//             No reset: outputs are qualified by the caller.
//  Revision : 1.0 - initial release
// ============================================================================
module cla_clk #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ci,
    output logic [WIDTH-1:0] o_s,
    output logic             o_co
);

    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] r_a_q;
    logic [WIDTH-1:0] r_b_q;
    logic             r_ci_q;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [NG-1:0]    w_gg;
    logic [NG-1:0]    w_pg;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s_d;
    logic             w_co_d;

    logic [WIDTH-1:0] r_s_q;
    logic             r_co_q;

    // Stage 1: capture operands.
    always_ff @(posedge clk) begin
        r_a_q  <= i_a;
        r_b_q  <= i_b;
        r_ci_q <= i_ci;
    end

    assign w_g = r_a_q & r_b_q;
    assign w_p = r_a_q ^ r_b_q;

    // Group generate/propagate for each 4-bit slice.
    for (genvar k = 0; k < NG; k++) begin : g_grp
        assign w_gg[k] = w_g[4*k+3]
                       | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
        assign w_pg[k] = &w_p[4*k +: 4];
    end

    // Lookahead carries inside each group; group carry-out from G/P.
    always_comb begin
        w_c    = '0;
        w_c[0] = r_ci_q;
        for (int k = 0; k < NG; k++) begin
            w_c[4*k+1] = w_g[4*k]
                       | (w_p[4*k] & w_c[4*k]);
            w_c[4*k+2] = w_g[4*k+1]
                       | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+3] = w_g[4*k+2]
                       | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+4] = w_gg[k] | (w_pg[k] & w_c[4*k]);
        end
    end

    assign w_s_d  = w_p ^ w_c[WIDTH-1:0];
    assign w_co_d = w_c[WIDTH];

    // Stage 2: register the sum and carry-out.
    always_ff @(posedge clk) begin
        r_s_q  <= w_s_d;
        r_co_q <= w_co_d;
    end

    assign o_s  = r_s_q;
    assign o_co = r_co_q;

endmodule : cla_clk
`default_nettype wire

// File: rtl/cla_share_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker. Rotates the request vector so
//             the priority pointer lands on bit 0, takes the lowest set bit,
//             and rotates the result back to an absolute requester index.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import cla_share_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [NREQ-1:0] w_rot;
    int              w_off;

    // Rotate right by ptr: w_rot[i] is requester (ptr + i) mod NREQ.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = i_req[IDX_W'(wrap_add(i, int'(i_ptr), NREQ))];
        end
    end

    // Lowest set bit of the rotated vector is the winner's offset from ptr.
    always_comb begin
        o_any = 1'b0;
        w_off = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!o_any && w_rot[i]) begin
                o_any = 1'b1;
                w_off = i;
            end
        end
    end

    // Rotate back to an absolute index and form the one-hot grant.
    always_comb begin
        o_idx   = IDX_W'(wrap_add(w_off, int'(i_ptr), NREQ));
        o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/cla_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cla_share_arb
//  Purpose  : Round-robin time-sharing of one registered CLA adder between
//             NREQ requesters. One grant per cycle; a tag pipeline matching
//             the adder latency routes each sum back with a one-hot strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module cla_share_arb
    import cla_share_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int LAT   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_ci,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_s,
    output logic                  rsp_co,
    output logic                  busy
);

    localparam int IDX_W = idx_width(NREQ);

    logic [IDX_W-1:0] r_ptr_q;
    logic [IDX_W-1:0] w_ptr_d;
    tag_t             r_tag_q [LAT];
    tag_t             w_tag_d [LAT];

    logic [NREQ-1:0]  w_pick_grant;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic [NREQ-1:0]  w_gnt;
    logic             w_xfer;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_ci;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr_q),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Grants are suppressed during reset so nothing enters the pipeline.
    always_comb begin
        w_gnt  = reset ? '0 : w_pick_grant;
        w_xfer = w_pick_any & ~reset;
    end

    assign req_ready = w_gnt;

    // AND-OR operand mux on the one-hot grant; all zeros when idle.
    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_ci = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_a  = w_a | (req_a[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
            w_b  = w_b | (req_b[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
            w_ci = w_ci | (req_ci[i] & w_gnt[i]);
        end
    end

    // Next priority pointer: one past the winner on a transfer, else hold.
    always_comb begin
        w_ptr_d = r_ptr_q;
        if (w_xfer) begin
            w_ptr_d = IDX_W'(wrap_add(int'(w_pick_idx), 1, NREQ));
        end
    end

    // Next tag pipeline: stage 0 records this cycle's transfer, the rest shift.
    always_comb begin
        w_tag_d[0] = {w_xfer, TAG_IDX_W'(w_pick_idx)};
        for (int k = 1; k < LAT; k++) begin
            w_tag_d[k] = r_tag_q[k-1];
        end
    end

    // Control state; reset discards every in-flight tag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_tag_q[k] <= '0;
            end
        end else begin
            r_ptr_q <= w_ptr_d;
            for (int k = 0; k < LAT; k++) begin
                r_tag_q[k] <= w_tag_d[k];
            end
        end
    end

    // Shared adder; LAT must equal its operand-to-sum register depth.
    cla_clk #(
        .WIDTH (WIDTH)
    ) u_cla (
        .clk  (clock),
        .i_a  (w_a),
        .i_b  (w_b),
        .i_ci (w_ci),
        .o_s  (rsp_s),
        .o_co (rsp_co)
    );

    // Decode the oldest tag into the one-hot response strobe.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = r_tag_q[LAT-1].valid
                         && (r_tag_q[LAT-1].idx == TAG_IDX_W'(i));
        end
    end

    // Busy while any stage holds a live add.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            busy = busy | r_tag_q[k].valid;
        end
    end

endmodule : cla_share_arb
`default_nettype wire

// File: tb/tb_cla_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_share_arb
//  Purpose  : Directed self-checking bench for cla_share_arb (NREQ=4,
//             WIDTH=32, LAT=2) with hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cla_share_arb;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ci;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_s;
    logic         rsp_co;
    logic         busy;

    int n_total = 0;
    int n_bad   = 0;

    // {co, s} each requester's fixed operands produce.
    // r0: FFFFFFFF+00000000+1, r1: 0000FFFF+FFFF0000+0,
    // r2: 135FA562+35614642+0, r3: 80000000+80000000+1
    logic [32:0] c_exp_sum [4] = '{33'h1_0000_0000, 33'h0_FFFF_FFFF,
                                   33'h0_48C0_EBA4, 33'h1_0000_0001};

    cla_share_arb #(
        .NREQ  (4),
        .WIDTH (32),
        .LAT   (2)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .rsp_valid (rsp_valid),
        .rsp_s     (rsp_s),
        .rsp_co    (rsp_co),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic ci);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_ci[i]         = ci;
    endtask

    int g2   [4] = '{1, 2, 1, 2};
    int gw   [2] = '{0, 2};
    int cnt  [4];

    initial begin
        reset     = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        req_ci    = '0;
        #1;
        chk("rst_ready_hi", 64'(req_ready), 64'h0);
        step;
        step;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        req_valid = 4'h0;
        reset     = 1'b0;

        set_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        set_op(1, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0);
        set_op(2, 32'h135F_A562, 32'h3561_4642, 1'b0);
        set_op(3, 32'h8000_0000, 32'h8000_0000, 1'b1);

        // Single request from requester 0.
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 64'(req_ready), 64'h1);
        step;
        req_valid = 4'b0000;
        #1;
        chk("t1_busy", 64'(busy), 64'h1);
        chk("t1_rsp_early", 64'(rsp_valid), 64'h0);
        step;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_s", 64'(rsp_s), 64'h0);
        chk("t1_rsp_co", 64'(rsp_co), 64'h1);
        step;
        chk("t1_rsp_done", 64'(rsp_valid), 64'h0);
        chk("t1_busy_done", 64'(busy), 64'h0);

        // Back-to-back: requesters 1 and 2 continuously valid (ptr starts at 1).
        for (int j = 0; j < 6; j++) begin
            req_valid = (j < 4) ? 4'b0110 : 4'b0000;
            #1;
            if (j < 4) chk($sformatf("t2_ready_%0d", j), 64'(req_ready), 64'(1 << g2[j]));
            if (j >= 2) begin
                chk($sformatf("t2_rsp_valid_%0d", j), 64'(rsp_valid), 64'(1 << g2[j-2]));
                chk($sformatf("t2_rsp_sum_%0d", j), 64'({rsp_co, rsp_s}), 64'(c_exp_sum[g2[j-2]]));
            end
            step;
        end

        // Reset pulse returns the pointer to 0.
        reset = 1'b1;
        step;
        reset = 1'b0;

        // Fairness: all four valid for 16 cycles.
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int j = 0; j < 18; j++) begin
            req_valid = (j < 16) ? 4'hF : 4'h0;
            #1;
            if (j < 16) begin
                chk($sformatf("t3_ready_%0d", j), 64'(req_ready), 64'(1 << (j % 4)));
                for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
            end
            if (j >= 1) chk($sformatf("t3_busy_%0d", j), 64'(busy), 64'h1);
            if (j >= 2) begin
                chk($sformatf("t3_rsp_valid_%0d", j), 64'(rsp_valid), 64'(1 << ((j - 2) % 4)));
                chk($sformatf("t3_rsp_sum_%0d", j), 64'({rsp_co, rsp_s}), 64'(c_exp_sum[(j - 2) % 4]));
            end
            step;
        end
        for (int i = 0; i < 4; i++) chk($sformatf("t3_count_%0d", i), 64'(cnt[i]), 64'd4);

        // Wrap: last grant was 3, now only 0 and 2 valid.
        for (int j = 0; j < 4; j++) begin
            req_valid = (j < 2) ? 4'b0101 : 4'b0000;
            #1;
            if (j < 2) chk($sformatf("t4_ready_%0d", j), 64'(req_ready), 64'(1 << gw[j]));
            if (j >= 2) begin
                chk($sformatf("t4_rsp_valid_%0d", j), 64'(rsp_valid), 64'(1 << gw[j-2]));
                chk($sformatf("t4_rsp_sum_%0d", j), 64'({rsp_co, rsp_s}), 64'(c_exp_sum[gw[j-2]]));
            end
            step;
        end

        // Reset mid-flight: transfer from 1, reset on the following edge.
        req_valid = 4'b0010;
        #1;
        chk("t5_ready", 64'(req_ready), 64'h2);
        step;
        reset     = 1'b1;
        req_valid = 4'b0000;
        step;
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk($sformatf("t5_rsp_valid_%0d", j), 64'(rsp_valid), 64'h0);
            chk($sformatf("t5_busy_%0d", j), 64'(busy), 64'h0);
            step;
        end
        // Without the reset the pointer would be 2 and pick 3; after it, 1 wins.
        req_valid = 4'b1010;
        #1;
        chk("t5_ptr_restart", 64'(req_ready), 64'h2);
        step;
        req_valid = 4'b0000;
        step;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("t5_rsp_sum", 64'({rsp_co, rsp_s}), 64'(c_exp_sum[1]));
        step;

        // Idle.
        for (int j = 0; j < 5; j++) begin
            req_valid = 4'b0000;
            #1;
            chk($sformatf("t6_ready_%0d", j), 64'(req_ready), 64'h0);
            chk($sformatf("t6_rsp_valid_%0d", j), 64'(rsp_valid), 64'h0);
            chk($sformatf("t6_busy_%0d", j), 64'(busy), 64'h0);
            step;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_cla_share_arb
`default_nettype wire
